note_sequencer: RTL

- Plays a stored melody by driving the 27-bit note input of note_decoder_full.
- Holds a small on-chip table of (note, duration) entries written by the host.
- On start it steps through the table, presenting each note for its duration and then a short silent gap.
- Stops at an end marker or the table end, optionally looping back to entry 0.

---
 rtl/note_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
`timescale 1ns/1ps
// note_sequencer: plays a host-written table of (note, duration) entries into
// note_decoder_full. Each note sounds for dur*TICK_DIV cycles, followed by a
// GAP_CYC-cycle silence. Playback ends at a zero-duration marker or the last
// entry, optionally wrapping back to entry 0.
module note_sequencer #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NOTE_W   = 27,
    parameter int unsigned DUR_W    = 8,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned GAP_CYC  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [NOTE_W-1:0] wr_note_i,
    input  logic [DUR_W-1:0]  wr_dur_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    output logic [NOTE_W-1:0] note_o,
    output logic              note_en_o,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GapW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned EntW  = NOTE_W + DUR_W;

    localparam logic [TickW-1:0]  TickLast = TickW'(TICK_DIV - 1);
    localparam logic [GapW-1:0]   GapLast  = GapW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);
    localparam bit                HasGap   = (GAP_CYC > 0);

    typedef enum logic [1:0] {StIdle, StFetch, StPlay, StGap} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                note_en_q, note_en_d;
    logic                done_q, done_d;
    logic [TickW-1:0]    tick_q, tick_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [GapW-1:0]     gap_q, gap_d;

    logic [EntW-1:0]     mem_q [DEPTH];
    logic [EntW-1:0]     rd_q;
    logic [ADDR_W-1:0]   rd_addr;
    logic [NOTE_W-1:0]   rd_note;
    logic [DUR_W-1:0]    rd_dur;
    logic                advance;
    logic                finish;

    assign rd_note = rd_q[EntW-1:DUR_W];
    assign rd_dur  = rd_q[DUR_W-1:0];

    // Table storage with registered read; a same-cycle write to the address
    // being read is forwarded so a late update is never missed.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= {wr_note_i, wr_dur_i};
        end
        if (wr_en_i && (wr_addr_i == rd_addr)) begin
            rd_q <= {wr_note_i, wr_dur_i};
        end else begin
            rd_q <= mem_q[rd_addr];
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            note_q     <= '0;
            note_en_q  <= 1'b0;
            done_q     <= 1'b0;
            tick_q     <= '0;
            dur_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            note_q     <= note_d;
            note_en_q  <= note_en_d;
            done_q     <= done_d;
            tick_q     <= tick_d;
            dur_q      <= dur_d;
            gap_q      <= gap_d;
        end
    end

    // Next-state logic; rd_addr always points at the entry FETCH will see.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        note_d     = note_q;
        note_en_d  = note_en_q;
        done_d     = 1'b0;
        tick_d     = tick_q;
        dur_d      = dur_q;
        gap_d      = gap_q;
        rd_addr    = cur_addr_q;
        advance    = 1'b0;
        finish     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    state_d    = StFetch;
                    cur_addr_d = '0;
                    rd_addr    = '0;
                end
            end
            StFetch: begin
                if (rd_dur != '0) begin
                    state_d   = StPlay;
                    note_d    = rd_note;
                    note_en_d = 1'b1;
                    dur_d     = rd_dur;
                    tick_d    = '0;
                end else if (loop_i && (cur_addr_q != '0)) begin
                    // Marker at entry 0 never loops, otherwise playback would spin.
                    state_d    = StFetch;
                    cur_addr_d = '0;
                    rd_addr    = '0;
                end else begin
                    finish = 1'b1;
                end
            end
            StPlay: begin
                if (tick_q == TickLast) begin
                    tick_d = '0;
                    if (dur_q == DUR_W'(1)) begin
                        note_d    = '0;
                        note_en_d = 1'b0;
                        if (HasGap) begin
                            state_d = StGap;
                            gap_d   = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        dur_d = dur_q - DUR_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    advance = 1'b1;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
        endcase

        // Last entry behaves like an end marker.
        if (advance) begin
            if (cur_addr_q != AddrLast) begin
                state_d    = StFetch;
                cur_addr_d = cur_addr_q + ADDR_W'(1);
                rd_addr    = cur_addr_q + ADDR_W'(1);
            end else if (loop_i) begin
                state_d    = StFetch;
                cur_addr_d = '0;
                rd_addr    = '0;
            end else begin
                finish = 1'b1;
            end
        end

        if (finish) begin
            state_d    = StIdle;
            cur_addr_d = '0;
            note_d     = '0;
            note_en_d  = 1'b0;
            done_d     = 1'b1;
        end

        // Abort overrides everything, including a completion in the same cycle.
        if (stop_i && (state_q != StIdle)) begin
            state_d    = StIdle;
            cur_addr_d = '0;
            note_d     = '0;
            note_en_d  = 1'b0;
            done_d     = 1'b0;
            tick_d     = '0;
            dur_d      = '0;
            gap_d      = '0;
        end
    end

    assign note_o     = note_q;
    assign note_en_o  = note_en_q;
    assign cur_addr_o = cur_addr_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;

endmodule
